mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 28, the line address width (byte address bits [31:4]).
REQ-002 The block SHALL have parameter DATA_W, default 128, the cache-line width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have ports I_read, I_write  input  1 each  I-cache request strobes.
REQ-006 The block SHALL have ports I_addr  input  ADDR_W  and  I_wdata  input  DATA_W  for the I-cache request.
REQ-007 The block SHALL have ports I_rdata  output  DATA_W  and  I_ready  output  1  for the I-cache response.
REQ-008 The block SHALL have ports D_read, D_write, D_addr, D_wdata, D_rdata and D_ready for the D-cache, with the same directions and widths as the I-cache ports.
REQ-009 The block SHALL have ports mem_read, mem_write  output  1 each;  mem_addr  output  ADDR_W;  mem_wdata  output  DATA_W.
REQ-010 The block SHALL have ports mem_rdata  input  DATA_W  and  mem_ready  input  1  from the shared slow memory.
REQ-011 The block SHALL have ports grant_I, grant_D  output  1 each, indicating the current owner of the memory.
REQ-012 The block SHALL have port proto_err  output  1, a sticky flag for a port asserting read and write together.

Function
REQ-013 The block SHALL implement the FSM states IDLE, BUSY_I, BUSY_D and RELEASE.
REQ-014 A port SHALL be requesting when its read or write strobe is 1.
REQ-015 In IDLE with exactly one port requesting, the block SHALL move to BUSY of that port at the next edge.
REQ-016 In IDLE with both ports requesting, the block SHALL grant the port not granted last (round-robin).
REQ-017 The last-grant register SHALL reset to I, so D wins the first conflict.
REQ-018 On the IDLE->BUSY edge, the block SHALL register the winner's addr, wdata and read/write into mem_addr, mem_wdata, mem_read and mem_write: a request seen in cycle t reaches memory in cycle t+1.
REQ-019 mem_* outputs SHALL hold constant throughout BUSY, regardless of later changes on the requester inputs.
REQ-020 If the winner has read=1 and write=1, write SHALL take precedence, mem_read SHALL stay 0, and proto_err SHALL set and hold until reset.
REQ-021 In BUSY_x, while mem_ready=1, x_ready SHALL be 1 combinationally and x_rdata SHALL equal mem_rdata (zero added return latency).
REQ-022 At that edge the block SHALL move to RELEASE and clear mem_read and mem_write.
REQ-023 A requester that drops its strobe before mem_ready SHALL NOT abort the access; the access SHALL complete and x_ready SHALL still pulse.
REQ-024 RELEASE SHALL last exactly one cycle and SHALL ignore requests, then return to IDLE; a port back-to-back is therefore re-arbitrated no earlier than 2 cycles after its ready.
REQ-025 The non-granted port's ready SHALL be 0 and its rdata SHALL be 0 at all times.
REQ-026 mem_ready in IDLE or RELEASE SHALL be ignored and not forwarded to either port.
REQ-027 grant_I SHALL be 1 exactly in BUSY_I, and grant_D exactly in BUSY_D.
REQ-028 With both ports continuously requesting, grants SHALL alternate D, I, D, I, ...; no port waits more than one full transaction.

Reset
REQ-029 While rst=1, the block SHALL go to IDLE immediately, independent of clk.
REQ-030 While rst=1, all outputs, mem_addr and mem_wdata SHALL be 0, proto_err SHALL be 0, and last-grant SHALL be I.
REQ-031 Reset asserted during BUSY SHALL drop the memory request; a late mem_ready after reset SHALL be ignored per REQ-026.

Verification
REQ-032 Scenario: I_read=1, I_addr=0x0000010 alone -> mem_read=1, mem_addr=0x0000010 next cycle, grant_I=1; when mem_ready pulses with mem_rdata=0xA5..A5, then I_ready=1 and I_rdata=0xA5..A5 in that same cycle; mem_read=0 the cycle after.
REQ-033 Scenario: I_read and D_write rise in the same cycle after reset -> D is served first; I is granted in the cycle after RELEASE; the grant sequence is D, I.
REQ-034 Scenario: both ports request continuously for 4 transactions -> grants are D, I, D, I; the cycle after each ready has mem_read=mem_write=0.
REQ-035 Scenario: D_read=D_write=1 with D_wdata=0x1234 -> mem_write=1, mem_read=0, mem_wdata=0x1234, and proto_err=1 remains set through later clean transactions.
REQ-036 Scenario: rst pulsed mid-BUSY_D, then mem_ready=1 two cycles later -> all outputs 0 during reset, D_ready never asserts, and the FSM is in IDLE.
REQ-037 Scenario: I drops I_read one cycle into BUSY_I and I_addr changes -> mem_addr unchanged, the access completes, and I_ready pulses once.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one slow memory between I-cache and D-cache ports
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_read,
  input  logic              I_write,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wdata,
  output logic [DATA_W-1:0] I_rdata,
  output logic              I_ready,
  input  logic              D_read,
  input  logic              D_write,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic [DATA_W-1:0] D_rdata,
  output logic              D_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_I,
  output logic              grant_D,
  output logic              proto_err
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;
  state_t state, state_nxt;
  logic last_d, i_req, d_req, any_req, pick_d, sel_read, sel_write;
  always_comb begin
    i_req = I_read | I_write;
    d_req = D_read | D_write;
    any_req = i_req | d_req;
    pick_d = d_req & (~i_req | ~last_d);
    sel_read = pick_d ? D_read : I_read;
    sel_write = pick_d ? D_write : I_write;
    state_nxt = state;
    if (state == IDLE)
      state_nxt = any_req ? (pick_d ? BUSY_D : BUSY_I) : IDLE;
    else if (state == RELEASE)
      state_nxt = IDLE;
    else if (mem_ready)
      state_nxt = RELEASE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      proto_err <= 1'b0;
      last_d <= 1'b0;
    end else if (state == IDLE && any_req) begin
      mem_addr <= pick_d ? D_addr : I_addr;
      mem_wdata <= pick_d ? D_wdata : I_wdata;
      mem_write <= sel_write;
      mem_read <= sel_read & ~sel_write;
      proto_err <= proto_err | (sel_read & sel_write);
      last_d <= pick_d;
    end else if ((state == BUSY_I || state == BUSY_D) && mem_ready) begin
      mem_read <= 1'b0;
      mem_write <= 1'b0;
    end
  end
  assign grant_I = state == BUSY_I;
  assign grant_D = state == BUSY_D;
  assign I_ready = grant_I & mem_ready;
  assign D_ready = grant_D & mem_ready;
  assign I_rdata = I_ready ? mem_rdata : '0;
  assign D_rdata = D_ready ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  logic clk = 1'b0, rst = 1'b1;
  logic I_read = 0, I_write = 0, D_read = 0, D_write = 0, mem_ready = 0;
  logic [AW-1:0] I_addr = '0, D_addr = '0, mem_addr;
  logic [DW-1:0] I_wdata = '0, D_wdata = '0, mem_wdata, mem_rdata = '0, I_rdata, D_rdata;
  logic I_ready, D_ready, mem_read, mem_write, grant_I, grant_D, proto_err;
  int errors = 0, checks = 0;
  logic [DW-1:0] a5 = {16{8'hA5}};
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .I_read(I_read), .I_write(I_write), .I_addr(I_addr), .I_wdata(I_wdata), .I_rdata(I_rdata), .I_ready(I_ready),
    .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata), .D_rdata(D_rdata), .D_ready(D_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant_I(grant_I), .grant_D(grant_D), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_mem_rw got %b exp 00", {mem_read, mem_write}); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if ({grant_I, grant_D, proto_err, I_ready, D_ready} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {grant_I, grant_D, proto_err, I_ready, D_ready}); end
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic test_single_read;
    I_read = 1; I_addr = 28'h0000010;
    step();
    I_read = 0;
    checks++; if ({mem_read, mem_write, grant_I, grant_D} !== 4'b1010) begin errors++; $display("FAIL single_grant got %b exp 1010", {mem_read, mem_write, grant_I, grant_D}); end
    checks++; if (mem_addr !== 28'h0000010) begin errors++; $display("FAIL single_addr got %h exp 0000010", mem_addr); end
    checks++; if (I_ready !== 1'b0) begin errors++; $display("FAIL single_wait_ready got %b exp 0", I_ready); end
    step();
    mem_ready = 1; mem_rdata = a5;
    #1;
    checks++; if ({I_ready, D_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {I_ready, D_ready}); end
    checks++; if (I_rdata !== a5) begin errors++; $display("FAIL single_rdata got %h exp %h", I_rdata, a5); end
    checks++; if (D_rdata !== '0) begin errors++; $display("FAIL single_d_rdata got %h exp 0", D_rdata); end
    step();
    mem_ready = 0;
    checks++; if ({mem_read, grant_I} !== 2'b00) begin errors++; $display("FAIL single_release got %b exp 00", {mem_read, grant_I}); end
    step();
  endtask
  task automatic test_conflict;
    do_reset();
    I_read = 1; I_addr = 28'h30; D_write = 1; D_addr = 28'h20; D_wdata = 128'hBEEF;
    step();
    D_write = 0;
    checks++; if ({grant_D, grant_I, mem_write, mem_read} !== 4'b1010) begin errors++; $display("FAIL conflict_d_first got %b exp 1010", {grant_D, grant_I, mem_write, mem_read}); end
    checks++; if (mem_addr !== 28'h20 || mem_wdata !== 128'hBEEF) begin errors++; $display("FAIL conflict_d_data got %h/%h exp 20/beef", mem_addr, mem_wdata); end
    mem_ready = 1;
    #1;
    checks++; if ({D_ready, I_ready} !== 2'b10) begin errors++; $display("FAIL conflict_d_ready got %b exp 10", {D_ready, I_ready}); end
    step();
    mem_ready = 1;
    #1;
    checks++; if ({grant_I, grant_D, mem_write, I_ready} !== 4'b0000) begin errors++; $display("FAIL conflict_release got %b exp 0000", {grant_I, grant_D, mem_write, I_ready}); end
    mem_ready = 0;
    step();
    checks++; if ({grant_I, grant_D} !== 2'b00) begin errors++; $display("FAIL conflict_idle got %b exp 00", {grant_I, grant_D}); end
    step();
    I_read = 0;
    checks++; if ({grant_I, mem_read, mem_addr} !== {2'b11, 28'h30}) begin errors++; $display("FAIL conflict_i_second got %b/%h exp 11/30", {grant_I, mem_read}, mem_addr); end
    mem_ready = 1;
    step();
    mem_ready = 0;
    step();
  endtask
  task automatic test_round_robin;
    logic [3:0] seq, exp_seq;
    int n;
    do_reset();
    I_read = 1; D_read = 1; seq = '0; exp_seq = 4'b1010;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (!(grant_I || grant_D) && n < 10) begin step(); n++; end
      checks++; if (n >= 10) begin errors++; $display("FAIL rr_timeout txn %0d got no grant exp grant", t); end
      seq[3-t] = grant_D;
      mem_ready = 1;
      step();
      mem_ready = 0;
      checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL rr_release txn %0d got %b exp 00", t, {mem_read, mem_write}); end
    end
    I_read = 0; D_read = 0;
    checks++; if (seq !== exp_seq) begin errors++; $display("FAIL rr_sequence got %b exp %b (1=D)", seq, exp_seq); end
    step();
  endtask
  task automatic test_proto_err;
    do_reset();
    D_read = 1; D_write = 1; D_wdata = 128'h1234;
    step();
    D_read = 0; D_write = 0;
    checks++; if ({mem_write, mem_read, proto_err} !== 3'b101) begin errors++; $display("FAIL proto_rw got %b exp 101", {mem_write, mem_read, proto_err}); end
    checks++; if (mem_wdata !== 128'h1234) begin errors++; $display("FAIL proto_wdata got %h exp 1234", mem_wdata); end
    mem_ready = 1;
    step();
    mem_ready = 0;
    step();
    I_read = 1;
    step();
    I_read = 0;
    mem_ready = 1;
    step();
    mem_ready = 0;
    step();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b exp 1", proto_err); end
  endtask
  task automatic test_reset_mid_busy;
    do_reset();
    D_read = 1; D_addr = 28'h55;
    step();
    D_read = 0;
    checks++; if ({grant_D, mem_read} !== 2'b11) begin errors++; $display("FAIL rstmid_busy got %b exp 11", {grant_D, mem_read}); end
    rst = 1;
    #1;
    checks++; if ({grant_D, grant_I, mem_read, mem_write, D_ready, proto_err} !== 6'b0 || mem_addr !== '0) begin errors++; $display("FAIL rstmid_async got %b/%h exp 0/0", {grant_D, grant_I, mem_read, mem_write, D_ready, proto_err}, mem_addr); end
    step();
    rst = 0;
    step();
    mem_ready = 1;
    #1;
    checks++; if ({D_ready, I_ready, grant_D, grant_I, mem_read} !== 5'b0) begin errors++; $display("FAIL rstmid_late_ready got %b exp 00000", {D_ready, I_ready, grant_D, grant_I, mem_read}); end
    checks++; if (D_rdata !== '0) begin errors++; $display("FAIL rstmid_rdata got %h exp 0", D_rdata); end
    step();
    mem_ready = 0;
    checks++; if ({grant_D, grant_I} !== 2'b00) begin errors++; $display("FAIL rstmid_idle got %b exp 00", {grant_D, grant_I}); end
  endtask
  task automatic test_drop_request;
    int pulses;
    do_reset();
    I_read = 1; I_addr = 28'h40;
    step();
    I_read = 0; I_addr = 28'h99;
    step();
    checks++; if ({grant_I, mem_read, mem_addr} !== {2'b11, 28'h40}) begin errors++; $display("FAIL drop_hold got %b/%h exp 11/40", {grant_I, mem_read}, mem_addr); end
    pulses = 0;
    mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (I_ready) pulses++;
      step();
    end
    mem_ready = 0;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL drop_pulses got %0d exp 1", pulses); end
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_conflict();
    test_round_robin();
    test_proto_err();
    test_reset_mid_busy();
    test_drop_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
